// File: rtl/puneh_pkg.sv
// Shared types and constants for the PUNEH memory-bus bridge.
// Provides the bridge FSM state enum, default bus widths and the error read value.
// ERR_RDATA is kept wide so any DATA_W up to MAX_DATA_W can slice it.
package puneh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } bus_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int MAX_DATA_W = 64;

    // Value returned to the core when a read times out.
    localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/puneh_timeout_ctr.sv
// Purpose: counts cycles a memory request has been outstanding; flags expiry.
// Latency: expired is combinational and asserts in the TIMEOUT-th enabled cycle.
// Backpressure: none; TIMEOUT=0 disables expiry entirely.
// Ports: clk, rst (async, active-high), clear (restart count), enable (count this
//        cycle), expired (this is the last allowed cycle).
module puneh_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of enabled cycles already elapsed, so the cycle
    // in which it equals TIMEOUT-1 is the TIMEOUT-th one.
    assign expired = (TIMEOUT != 0) && enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (TIMEOUT != 0) && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/puneh_bus_bridge.sv
// Purpose: bridges controller rd/wr strobes onto a registered req/ack memory bus.
// Latency: reads stall the core for 1 + (request cycles until ack), DONE releases it.
// Backpressure: core_stall holds the core; posted writes release it on acceptance.
// Ports: core_rd/core_wr/core_addr/core_wdata in, core_rdata/core_stall out;
//        mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in; bus_err pulse.
module puneh_bus_bridge
    import puneh_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TIMEOUT   = 255,
    parameter int POSTED_WR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam bit POSTED = (POSTED_WR != 0);

    bus_state_e        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              bus_err_q,   bus_err_d;
    logic              accept;
    logic              expired;

    puneh_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (mem_req_q),
        .expired (expired)
    );

    // A write accepted in IDLE with posting enabled lets the core run on.
    assign core_stall = (core_rd | core_wr) & (state_q != DONE)
                      & !((state_q == IDLE) & core_wr & POSTED);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                // Write wins when both strobes are raised together.
                if (core_wr) begin
                    accept      = 1'b1;
                    state_d     = WR_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                end else if (core_rd) begin
                    accept     = 1'b1;
                    state_d    = RD_REQ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = core_addr;
                end
            end
            RD_REQ, WR_REQ: begin
                // An ack in the expiry cycle still completes normally.
                if (mem_ack || expired) begin
                    mem_req_d = 1'b0;
                    bus_err_d = !mem_ack;
                    if (state_q == RD_REQ) begin
                        rdata_d = mem_ack ? mem_rdata : ERR_RDATA[DATA_W-1:0];
                    end
                    state_d = ((state_q == WR_REQ) && POSTED) ? IDLE : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign core_rdata = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign bus_err    = bus_err_q;

endmodule
